// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen: parametrised video timing and test-pattern generator.
// Feeds a TMDS encoder with hs/vs/de and RGB, all aligned to one another.
//
// Ports:
//   clk          pixel clock
//   rst          synchronous active-high reset
//   mode         pattern select (0 bars, 1 scrolling gradient, 2 checker, 3 solid)
//   solid_rgb    {r,g,b} colour used by mode 3
//   hs, vs       syncs with the configured polarity applied
//   de           data enable
//   rgb_r/g/b    pixel data, zero outside the active area
//   active_x/y   coordinates inside the active area, zero outside
//   frame_start  one-cycle pulse on the first output cycle of a frame
//   frame_cnt    completed-frame counter, wraps at 2^16
//
// Pipeline: counters -> stage 1 (sync, de, x/y, frame flag) -> stage 2
// (pattern + delayed sideband). Outputs reflect counter state two cycles ago.
module hdmi_timing_gen #(
    parameter int unsigned H_ACTIVE   = 1280,
    parameter int unsigned H_FP       = 110,
    parameter int unsigned H_SYNC     = 40,
    parameter int unsigned H_BP       = 220,
    parameter int unsigned V_ACTIVE   = 720,
    parameter int unsigned V_FP       = 5,
    parameter int unsigned V_SYNC     = 5,
    parameter int unsigned V_BP       = 20,
    parameter int unsigned HS_POL     = 1,
    parameter int unsigned VS_POL     = 1,
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned COLOR_W    = 8,
    parameter int unsigned CHECK_LOG2 = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic [3*COLOR_W-1:0]   solid_rgb,
    output logic                   hs,
    output logic                   vs,
    output logic                   de,
    output logic [COLOR_W-1:0]     rgb_r,
    output logic [COLOR_W-1:0]     rgb_g,
    output logic [COLOR_W-1:0]     rgb_b,
    output logic [CNT_W-1:0]       active_x,
    output logic [CNT_W-1:0]       active_y,
    output logic                   frame_start,
    output logic [15:0]            frame_cnt
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned H_START = H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned V_START = V_SYNC + V_BP;
    localparam int unsigned BAR_W   = H_ACTIVE / 8;
    localparam logic        HS_ACT  = (HS_POL != 0);
    localparam logic        VS_ACT  = (VS_POL != 0);

    // Counter stage
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [15:0]      fc_int;

    logic h_last_c;
    logic v_last_c;
    assign h_last_c = (h_cnt == CNT_W'(H_TOTAL - 1));
    assign v_last_c = (v_cnt == CNT_W'(V_TOTAL - 1));

    // Raster counters; the frame count steps on the wrap back to (0,0)
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt  <= '0;
            v_cnt  <= '0;
            fc_int <= '0;
        end else if (h_last_c) begin
            h_cnt <= '0;
            if (v_last_c) begin
                v_cnt  <= '0;
                fc_int <= fc_int + 16'd1;
            end else begin
                v_cnt <= v_cnt + CNT_W'(1);
            end
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    // Stage 1 decode from counter values
    logic h_act_c;
    logic v_act_c;
    logic de_raw_c;
    logic top_c;
    assign h_act_c  = (h_cnt >= CNT_W'(H_START)) && (h_cnt < CNT_W'(H_START + H_ACTIVE));
    assign v_act_c  = (v_cnt >= CNT_W'(V_START)) && (v_cnt < CNT_W'(V_START + V_ACTIVE));
    assign de_raw_c = h_act_c && v_act_c;
    assign top_c    = (h_cnt == '0) && (v_cnt == '0);

    logic                 hs_s1;
    logic                 vs_s1;
    logic                 de_s1;
    logic [CNT_W-1:0]     x_s1;
    logic [CNT_W-1:0]     y_s1;
    logic                 fs_s1;
    logic [15:0]          fc_s1;
    logic [1:0]           mode_lat;
    logic [3*COLOR_W-1:0] solid_lat;

    // Stage 1 registers; mode/colour latch only at the frame origin so the
    // first pixel of a frame already sees the new selection
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_s1     <= 1'b0;
            vs_s1     <= 1'b0;
            de_s1     <= 1'b0;
            x_s1      <= '0;
            y_s1      <= '0;
            fs_s1     <= 1'b0;
            fc_s1     <= '0;
            mode_lat  <= 2'd0;
            solid_lat <= '0;
        end else begin
            hs_s1 <= (h_cnt < CNT_W'(H_SYNC));
            vs_s1 <= (v_cnt < CNT_W'(V_SYNC));
            de_s1 <= de_raw_c;
            x_s1  <= de_raw_c ? (h_cnt - CNT_W'(H_START)) : '0;
            y_s1  <= de_raw_c ? (v_cnt - CNT_W'(V_START)) : '0;
            fs_s1 <= top_c;
            fc_s1 <= fc_int;
            if (top_c) begin
                mode_lat  <= mode;
                solid_lat <= solid_rgb;
            end
        end
    end

    // Colour bar index: count thresholds passed, saturates at 7
    logic [2:0] bar_idx_c;
    always_comb begin
        bar_idx_c = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x_s1 >= CNT_W'(k * BAR_W)) begin
                bar_idx_c = 3'(k);
            end
        end
    end

    // Bar colour as one bit per {r,g,b}
    logic [2:0] bar_bits_c;
    always_comb begin
        bar_bits_c = 3'b000;
        case (bar_idx_c)
            3'd0: bar_bits_c = 3'b111;  // white
            3'd1: bar_bits_c = 3'b110;  // yellow
            3'd2: bar_bits_c = 3'b011;  // cyan
            3'd3: bar_bits_c = 3'b010;  // green
            3'd4: bar_bits_c = 3'b101;  // magenta
            3'd5: bar_bits_c = 3'b100;  // red
            3'd6: bar_bits_c = 3'b001;  // blue
            default: bar_bits_c = 3'b000;  // black
        endcase
    end

    logic [COLOR_W-1:0] grad_c;
    logic               check_c;
    assign grad_c  = COLOR_W'(x_s1) + COLOR_W'(fc_s1);
    assign check_c = x_s1[CHECK_LOG2] ^ y_s1[CHECK_LOG2];

    // Pattern select
    logic [3*COLOR_W-1:0] pix_c;
    always_comb begin
        pix_c = '0;
        case (mode_lat)
            2'd0: pix_c = {{COLOR_W{bar_bits_c[2]}}, {COLOR_W{bar_bits_c[1]}},
                           {COLOR_W{bar_bits_c[0]}}};
            2'd1: pix_c = {grad_c, grad_c, grad_c};
            2'd2: pix_c = {(3*COLOR_W){check_c}};
            default: pix_c = solid_lat;
        endcase
    end

    // Stage 2 output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hs          <= ~HS_ACT;
            vs          <= ~VS_ACT;
            de          <= 1'b0;
            rgb_r       <= '0;
            rgb_g       <= '0;
            rgb_b       <= '0;
            active_x    <= '0;
            active_y    <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            hs          <= hs_s1 ? HS_ACT : ~HS_ACT;
            vs          <= vs_s1 ? VS_ACT : ~VS_ACT;
            de          <= de_s1;
            rgb_r       <= de_s1 ? pix_c[3*COLOR_W-1:2*COLOR_W] : '0;
            rgb_g       <= de_s1 ? pix_c[2*COLOR_W-1:COLOR_W]   : '0;
            rgb_b       <= de_s1 ? pix_c[COLOR_W-1:0]           : '0;
            active_x    <= x_s1;
            active_y    <= y_s1;
            frame_start <= fs_s1;
            frame_cnt   <= fc_s1;
        end
    end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Testbench for hdmi_timing_gen on a small 24x8 raster. Outputs are compared
// every cycle against a position/frame based reference model.
module tb_hdmi_timing_gen;

    localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA = 4,  VFP = 1, VSY = 2, VBP = 1;
    localparam int HT = HA + HFP + HSY + HBP;   // 24
    localparam int VT = VA + VFP + VSY + VBP;   // 8
    localparam int FT = HT * VT;                // 192
    localparam int HST = HSY + HBP;
    localparam int VST = VSY + VBP;
    localparam int HPOL = 0, VPOL = 0;
    localparam int CLOG = 2;
    localparam int BW = HA / 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd1;
    logic [23:0] solid_rgb = 24'h0;
    logic        hs, vs, de, frame_start;
    logic [7:0]  rgb_r, rgb_g, rgb_b;
    logic [11:0] active_x, active_y;
    logic [15:0] frame_cnt;

    hdmi_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(HPOL), .VS_POL(VPOL), .CNT_W(12), .COLOR_W(8),
        .CHECK_LOG2(CLOG)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .solid_rgb(solid_rgb),
        .hs(hs), .vs(vs), .de(de),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
        .active_x(active_x), .active_y(active_y),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n = 0;                 // edges since reset release
    int fm [64];               // mode in force for each frame
    logic [23:0] fsol [64];    // solid colour in force for each frame
    logic [23:0] bars [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d after release)", tag, got, exp, n);
        end
    endtask

    // Expected outputs derived from raster position and frame number
    task automatic check_outputs();
        int p, h, v, f, x, y, g;
        logic e_hs, e_vs, e_de, e_fs;
        logic [23:0] e_rgb;
        logic [15:0] e_fc;
        if (n < 2) begin
            e_hs = (HPOL == 0); e_vs = (VPOL == 0); e_de = 1'b0; e_fs = 1'b0;
            e_rgb = 24'h0; e_fc = 16'h0; x = 0; y = 0;
        end else begin
            p = n - 2;
            h = p % HT;
            v = (p / HT) % VT;
            f = p / FT;
            e_hs = (h < HSY) ? (HPOL != 0) : (HPOL == 0);
            e_vs = (v < VSY) ? (VPOL != 0) : (VPOL == 0);
            e_de = (h >= HST) && (h < HST + HA) && (v >= VST) && (v < VST + VA);
            x = e_de ? h - HST : 0;
            y = e_de ? v - VST : 0;
            e_fs = (p % FT == 0);
            e_fc = 16'(f);
            e_rgb = 24'h0;
            if (e_de) begin
                case (fm[f % 64])
                    0: e_rgb = bars[(x / BW > 7) ? 7 : x / BW];
                    1: begin g = (x + f) % 256; e_rgb = {8'(g), 8'(g), 8'(g)}; end
                    2: e_rgb = (((x >> CLOG) + (y >> CLOG)) % 2 == 1) ? 24'hFFFFFF : 24'h0;
                    default: e_rgb = fsol[f % 64];
                endcase
            end
        end
        chk("hs", 32'(hs), 32'(e_hs));
        chk("vs", 32'(vs), 32'(e_vs));
        chk("de", 32'(de), 32'(e_de));
        chk("rgb", 32'({rgb_r, rgb_g, rgb_b}), 32'(e_rgb));
        chk("active_x", 32'(active_x), 32'(x));
        chk("active_y", 32'(active_y), 32'(y));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("frame_cnt", 32'(frame_cnt), 32'(e_fc));
    endtask

    // One clock: advance the model, then sample outputs 1 time unit later
    task automatic step();
        @(posedge clk);
        if (rst) begin
            n = 0;
        end else begin
            n++;
            if ((n - 1) % FT == 0) begin
                fm[((n - 1) / FT) % 64]   = int'(mode);
                fsol[((n - 1) / FT) % 64] = solid_rgb;
            end
        end
        #1;
        check_outputs();
    endtask

    initial begin
        bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
        bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
        for (int i = 0; i < 64; i++) begin
            fm[i] = 0;
            fsol[i] = 24'h0;
        end

        // Reset held five cycles; frames 0 and 1 scroll, 2 bars, 3 solid, 4+ checker
        rst = 1'b1;
        repeat (5) step();
        rst = 1'b0;
        for (int k = 0; k < 6 * FT; k++) begin
            step();
            if (n == FT + 100) mode = 2'd0;
            if (n == 2 * FT + 100) begin
                mode = 2'd3;
                solid_rgb = 24'h123456;
            end
            if (n == 3 * FT + 100) mode = 2'd2;
            if (n == 5 * FT + 106) begin
                // counter at v=4, h=10: reset mid-frame
                rst = 1'b1;
                step();
                rst = 1'b0;
                break;
            end
        end

        // Random mode and colour changes at arbitrary times
        for (int k = 0; k < 8 * FT; k++) begin
            if ($urandom_range(0, 49) == 0) begin
                mode = 2'($urandom_range(0, 3));
                solid_rgb = 24'($urandom);
            end
            if ($urandom_range(0, 2999) == 0) rst = 1'b1;
            step();
            rst = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hdmi_timing_gen.md
# hdmi_timing_gen

Parametrised video timing and test-pattern generator for the HDMI output path. It replaces the fixed-resolution driver with a timing core that takes all porch, sync and active sizes, sync polarities and colour width as parameters. It adds four selectable test patterns, frame-boundary mode switching and a frame counter. It feeds the TMDS encoder with aligned `hs`/`vs`/`de`/RGB.

## Interface
- `H_ACTIVE`, 1280: active pixels per line
- `H_FP`, 110: horizontal front porch, in pixels
- `H_SYNC`, 40: horizontal sync width, in pixels
- `H_BP`, 220: horizontal back porch, in pixels
- `V_ACTIVE`, 720: active lines per frame
- `V_FP`, 5: vertical front porch, in lines
- `V_SYNC`, 5: vertical sync width, in lines
- `V_BP`, 20: vertical back porch, in lines
- `HS_POL`, 1: sync polarity; 1 means active-high
- `VS_POL`, 1: sync polarity; 1 means active-high
- `CNT_W`, 12: counter and coordinate width; must hold `H_TOTAL-1` and `V_TOTAL-1`
- `COLOR_W`, 8: bits per colour channel
- `CHECK_LOG2`, 5: checkerboard square size is 2^`CHECK_LOG2` pixels

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  reset; one clock, synchronous, active-high
- `mode`  in  2  pattern select: 0 = colour bars, 1 = scrolling gradient, 2 = checkerboard, 3 = solid
- `solid_rgb`  in  3*`COLOR_W`  colour for mode 3, packed {r,g,b}
- `hs`  out  1  horizontal sync, with `HS_POL` applied
- `vs`  out  1  vertical sync, with `VS_POL` applied
- `de`  out  1  data enable
- `rgb_r`, `rgb_g`, `rgb_b`  out  `COLOR_W` each  pixel data
- `active_x`, `active_y`  out  `CNT_W` each  coordinates within the active area, aligned with `de`
- `frame_start`  out  1  one-cycle pulse, aligned with the first output cycle of each frame
- `frame_cnt`  out  16  completed-frame counter; wraps modulo 2^16

## Operation
- Derived values:
  - `H_TOTAL` = `H_SYNC`+`H_BP`+`H_ACTIVE`+`H_FP`; `H_START` = `H_SYNC`+`H_BP`.
  - `V_TOTAL` and `V_START` are formed the same way.
- Counter stage:
  - `h_cnt` runs 0..`H_TOTAL-1` and then wraps to 0.
  - `v_cnt` increments when `h_cnt` = `H_TOTAL-1`. It wraps to 0 after `V_TOTAL-1`.
- Sync and enable, from counter values:
  - Sync is asserted for `h_cnt` < `H_SYNC` and for `v_cnt` < `V_SYNC`.
  - `de_raw` = (`h_cnt` in [`H_START`, `H_START+H_ACTIVE`)) AND (`v_cnt` in [`V_START`, `V_START+V_ACTIVE`)).
  - In the active area, x = `h_cnt`−`H_START` and y = `v_cnt`−`V_START`. Outside the active area, x and y are held at 0.
- Frame-boundary latch: when `h_cnt`=0 and `v_cnt`=0, the block latches `mode` and `solid_rgb`. Input changes mid-frame never affect the current frame.
- `frame_cnt` increments when the counter stage passes from (`H_TOTAL-1`, `V_TOTAL-1`) to (0,0).
- Patterns (driven only while `de`=1; RGB is forced to 0 when `de`=0):
  - Mode 0, colour bars. `BAR_W` = `H_ACTIVE`/8, computed at elaboration. Bar index = x/`BAR_W`, found by threshold compare with no divider, saturating at 7. Bar colours in order: white, yellow, cyan, green, magenta, red, blue, black. Each component is all-ones or 0.
  - Mode 1, scrolling gradient. r = g = b = (x + `frame_cnt`)[`COLOR_W-1`:0], wrapping modulo 2^`COLOR_W`.
  - Mode 2, checkerboard. All-ones when x[`CHECK_LOG2`] XOR y[`CHECK_LOG2`] = 1, otherwise 0.
  - Mode 3, solid: the latched `solid_rgb`.
- Reset, including reset asserted mid-frame. On the next edge:
  - counters and `frame_cnt` go to 0;
  - latched mode goes to 0;
  - `hs` = !`HS_POL` and `vs` = !`VS_POL`;
  - `de`, RGB, `active_x`, `active_y` and `frame_start` go to 0;
  - all pipeline registers are cleared.

## Timing
- Pipeline depth:
  - Stage 1 registers sync, `de_raw`, x, y and the frame-start flag from the counters.
  - Stage 2 registers the pattern and delays all sideband signals by one cycle.
  - All outputs are therefore aligned to counter state two cycles earlier.
- After `rst` deasserts, the first edge with `rst`=0 loads stage 1 from counter (0,0). Outputs show that state after the second such edge.
- `frame_start` is high for exactly 1 cycle per `H_TOTAL`*`V_TOTAL` cycles.
- The `frame_cnt` output updates in the same cycle that `frame_start` is high.
- `de` is high for exactly `H_ACTIVE` consecutive cycles per active line and low for the rest of the line.
- A `mode` change sampled at counter (0,0) takes effect on the `de` cycles of that frame. A change at any other time waits for the next frame.

## Test plan
Test parameters for all scenarios: `H_ACTIVE`=16, `H_FP`=2, `H_SYNC`=3, `H_BP`=3 (`H_TOTAL`=24); `V_ACTIVE`=4, `V_FP`=1, `V_SYNC`=2, `V_BP`=1 (`V_TOTAL`=8).
- Reset and polarity:
  - Hold `rst` 5 cycles with `HS_POL`=0 → `hs`=1, `vs`=1, `de`=0, RGB=0.
  - Release `rst` → first `frame_start` appears 2 edges later.
  - After that, `hs` is low for 3 of every 24 cycles.
- Frame geometry:
  - Run 3 frames → 192-cycle `frame_start` period.
  - `de` is high for 16 consecutive cycles on `v_cnt` 3..6 only, i.e. 64 `de` cycles per frame.
  - `active_x` goes 0..15 and `active_y` goes 0..3.
- Colour bars (mode 0): each row reads white ×2, yellow ×2, …, black ×2 (`BAR_W`=2).
- Scroll (mode 1): in frame k (frame k's `frame_cnt`=k), pixel x=5 has value (5+k) mod 256. Check k=0 and k=1.
- Frame-boundary mode change:
  - Start in mode 3 with `solid_rgb`=0x123456.
  - Switch to mode 2 in mid-frame → the rest of the frame stays 0x123456.
  - Next frame is the checkerboard.
- Reset mid-frame:
  - Assert `rst` at `v_cnt`=4, `h_cnt`=10 → outputs take reset values on the next edge; `frame_cnt`=0.
  - On release, the next `frame_start` appears 2 cycles later.
